// File: rtl/atm_pkg.sv
// Shared ATM definitions: keypad key codes and the PIN entry state encoding.
package atm_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } pin_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_unit_idle_timer.sv
// Inactivity timer: counts enabled cycles without a restart and flags the
// cycle on which the count would reach TIMEOUT_CYCLES.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired is combinational so a key on the expiry cycle (restart) can veto it
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (!enable || restart) begin
      cnt_d = '0;
    end else begin
      expired = (cnt_q == LAST);
      if (cnt_q != LIMIT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pin_entry_unit.sv
// Keypad PIN entry front end: buffers BCD digits, compares against the account
// PIN on ENTER and reports complete attempts to the ATM controller.
//
// Handshake: key_valid is a single-cycle strobe with no back-pressure; every
// strobe is consumed on the edge that samples it, one key per cycle.
module pin_entry_unit
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    session_active,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  output logic                    pin_entered,
  output logic                    pin_correct,
  output logic [3:0]              digit_count,
  output logic                    entry_error,
  output logic                    entry_timeout,
  output pin_state_t              dbg_state
);

  localparam int BW = 4 * PIN_DIGITS;
  localparam logic [3:0] FULL_CNT = 4'(PIN_DIGITS);

  pin_state_t    state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    count_q, count_d;
  logic          entered_q, entered_d;
  logic          correct_q, correct_d;
  logic          error_q, error_d;
  logic          timeout_q, timeout_d;

  logic          timer_en;
  logic          timer_expired;
  logic [BW-1:0] buf_shift;

  assign timer_en  = session_active && (state_q == COLLECT) && (count_q != 4'd0);
  assign buf_shift = (buf_q << 4) | BW'(key_code);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .restart(key_valid),
    .expired(timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    count_d   = count_q;
    entered_d = entered_q;
    correct_d = correct_q;
    error_d   = 1'b0;
    timeout_d = 1'b0;

    // Session end outranks any key sampled on the same edge
    if (!session_active) begin
      state_d   = IDLE;
      buf_d     = '0;
      count_d   = '0;
      entered_d = 1'b0;
      correct_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COLLECT;
        end

        COLLECT: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              if (count_q != FULL_CNT) begin
                buf_d   = buf_shift;
                count_d = count_q + 4'd1;
              end else begin
                error_d = 1'b1;
              end
            end else if (key_code == KEY_CLEAR) begin
              buf_d   = '0;
              count_d = '0;
            end else if (key_code == KEY_ENTER) begin
              if (count_q == FULL_CNT) begin
                correct_d = (buf_q == stored_pin);
                entered_d = 1'b1;
                count_d   = '0;
                state_d   = READY;
              end else begin
                error_d = 1'b1;
              end
            end else begin
              error_d = 1'b1;
            end
          end else if (timer_expired) begin
            buf_d     = '0;
            count_d   = '0;
            timeout_d = 1'b1;
          end
        end

        READY: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              entered_d = 1'b0;
              correct_d = 1'b0;
              buf_d     = BW'(key_code);
              count_d   = 4'd1;
              state_d   = COLLECT;
            end else if (key_code == KEY_CLEAR) begin
              entered_d = 1'b0;
              correct_d = 1'b0;
              buf_d     = '0;
              count_d   = '0;
              state_d   = COLLECT;
            end else begin
              error_d = 1'b1;
            end
          end
        end

        default: begin
          state_d   = IDLE;
          buf_d     = '0;
          count_d   = '0;
          entered_d = 1'b0;
          correct_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      count_q   <= '0;
      entered_q <= 1'b0;
      correct_q <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      count_q   <= count_d;
      entered_q <= entered_d;
      correct_q <= correct_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  assign pin_entered   = entered_q;
  assign pin_correct   = correct_q;
  assign digit_count   = count_q;
  assign entry_error   = error_q;
  assign entry_timeout = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pin_entry_unit.sv
// Self-checking bench for pin_entry_unit: directed scenarios followed by random
// keystrokes, checked every cycle against a digit-queue reference model.
module tb_pin_entry_unit;
  import atm_pkg::*;

  localparam int PD = 4;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          session_active;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [4*PD-1:0] stored_pin;
  logic          pin_entered;
  logic          pin_correct;
  logic [3:0]    digit_count;
  logic          entry_error;
  logic          entry_timeout;
  pin_state_t    dbg_state;

  int n_checks;
  int n_errors;
  int n_step;

  // reference model
  pin_state_t m_state;
  int         m_q[$];
  logic       m_entered;
  logic       m_correct;
  logic       m_err;
  logic       m_tmo;
  int         m_idle;

  pin_entry_unit #(
    .PIN_DIGITS    (PD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .session_active(session_active),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .stored_pin    (stored_pin),
    .pin_entered   (pin_entered),
    .pin_correct   (pin_correct),
    .digit_count   (digit_count),
    .entry_error   (entry_error),
    .entry_timeout (entry_timeout),
    .dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_value();
    logic [31:0] v;
    v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state   = IDLE;
    m_q.delete();
    m_entered = 1'b0;
    m_correct = 1'b0;
    m_err     = 1'b0;
    m_tmo     = 1'b0;
    m_idle    = 0;
  endtask

  task automatic model_step(input logic s, input logic kv, input logic [3:0] code);
    m_err = 1'b0;
    m_tmo = 1'b0;
    if (!s) begin
      model_reset();
    end else if (m_state == IDLE) begin
      m_state = COLLECT;
      m_idle  = 0;
    end else if (m_state == COLLECT) begin
      if (kv) begin
        m_idle = 0;
        if (code < 10) begin
          if (m_q.size() < PD) m_q.push_back(int'(code));
          else m_err = 1'b1;
        end else if (code == 4'hA) begin
          m_q.delete();
        end else if (code == 4'hB) begin
          if (m_q.size() == PD) begin
            m_entered = 1'b1;
            m_correct = (q_value() == 32'(stored_pin));
            m_q.delete();
            m_state = READY;
          end else begin
            m_err = 1'b1;
          end
        end else begin
          m_err = 1'b1;
        end
      end else if (m_q.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_q.delete();
          m_tmo  = 1'b1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end else begin
      if (kv) begin
        if (code < 10) begin
          m_entered = 1'b0;
          m_correct = 1'b0;
          m_q.delete();
          m_q.push_back(int'(code));
          m_idle  = 0;
          m_state = COLLECT;
        end else if (code == 4'hA) begin
          m_entered = 1'b0;
          m_correct = 1'b0;
          m_q.delete();
          m_idle  = 0;
          m_state = COLLECT;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("digit_count",   32'(digit_count),   32'(m_q.size()));
    check("pin_entered",   32'(pin_entered),   32'(m_entered));
    check("pin_correct",   32'(pin_correct),   32'(m_correct));
    check("entry_error",   32'(entry_error),   32'(m_err));
    check("entry_timeout", 32'(entry_timeout), 32'(m_tmo));
    check("state",         32'(dbg_state),     32'(m_state));
  endtask

  task automatic step(input logic s, input logic kv, input logic [3:0] code);
    session_active = s;
    key_valid      = kv;
    key_code       = code;
    @(posedge clk);
    model_step(s, kv, code);
    #1;
    n_step++;
    check_outputs();
    key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b1, 1'b1, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    int r;
    logic [3:0] c;
    logic [31:0] rv;

    n_checks = 0;
    n_errors = 0;
    n_step   = 0;
    reset = 1'b1;
    session_active = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    stored_pin = 16'h1234;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // correct PIN
    idle(1);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER);
    check("correct_entered", 32'(pin_entered), 32'd1);
    check("correct_result",  32'(pin_correct), 32'd1);
    idle(3);
    key(4'h5);
    check("restart_count", 32'(digit_count), 32'd1);

    // wrong PIN then clear
    key(KEY_CLEAR);
    key(4'h1); key(4'h2); key(4'h3); key(4'h5); key(KEY_ENTER);
    check("wrong_result", 32'(pin_correct), 32'd0);
    key(KEY_CLEAR);

    // malformed entry
    key(4'h1); key(4'h2); key(KEY_ENTER);
    check("premature_enter", 32'(entry_error), 32'd1);
    key(4'h3); key(4'h4); key(4'h7);
    check("extra_digit", 32'(entry_error), 32'd1);
    key(KEY_ENTER);
    check("buffer_kept", 32'(pin_correct), 32'd1);
    key(4'hE);
    key(KEY_ENTER);
    key(KEY_CLEAR);
    key(4'hE);
    check("invalid_key", 32'(entry_error), 32'd1);

    // timeout, then key on the expiry cycle
    key(4'h9);
    idle(TO);
    check("timeout_pulse", 32'(entry_timeout), 32'd1);
    idle(2);
    key(4'h9);
    idle(TO - 1);
    key(4'h3);
    check("timeout_vetoed", 32'(digit_count), 32'd2);
    idle(1);

    // session drop with simultaneous key
    key(KEY_CLEAR);
    key(4'h1); key(4'h2); key(4'h3);
    step(1'b0, 1'b1, 4'h4);
    check("drop_count", 32'(digit_count), 32'd0);
    idle(1);

    // reset mid-entry
    key(4'h1); key(4'h2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #2 reset = 1'b0;
    idle(1);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER);
    check("post_reset_result", 32'(pin_correct), 32'd1);

    // random phase
    for (int it = 0; it < 700; it++) begin
      r = int'($urandom_range(99));
      if (r < 2) begin
        step(1'b0, 1'b0, 4'h0);
      end else if (r < 6) begin
        idle(int'($urandom_range(TO + 2, TO - 1)));
      end else if (r < 35) begin
        idle(1);
      end else begin
        r = int'($urandom_range(99));
        if (r < 65)      c = 4'($urandom_range(9));
        else if (r < 72) c = KEY_CLEAR;
        else if (r < 90) c = KEY_ENTER;
        else             c = 4'($urandom_range(15, 12));
        if (c == KEY_ENTER && m_state == COLLECT && m_q.size() == PD &&
            $urandom_range(1) == 1) begin
          rv = q_value();
          stored_pin = rv[4*PD-1:0];
        end else if ($urandom_range(19) == 0) begin
          for (int d = 0; d < PD; d++) stored_pin[4*d +: 4] = 4'($urandom_range(9));
        end
        key(c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
